reduceron_run_monitor: RTL
==========================

Name: reduceron_run_monitor

Overview:
Synthesisable run monitor for a Reduceron core.
- Samples the core's result, state, heap-pointer and finish outputs every clock.
- Keeps cycle, GC and heap statistics.
- Queues timestamped events (GC start/finish, heap-pointer change, finish) in a small FIFO, drained by a host or debug port over a valid/ready handshake.
- Captures and holds the final result when finish rises.

Parameters:
RES_W, 16, result bus width
TAG_W, 3, low result bits holding the tag; value = result >> TAG_W
STATE_W, 7, core state bus width
GC_BIT, 5, index of the GC-active bit within state
HEAP_W, 13, heap pointer width
CNT_W, 32, width of all counters and timestamps
EV_DEPTH, 8, event FIFO depth (power of two, >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
result  in  RES_W  core result bus
state  in  STATE_W  core state bus
heap  in  HEAP_W  core heap pointer
finish  in  1  core finish flag
clear  in  1  synchronous restart of monitor (flush + zero)
done  out  1  finish captured; monitor frozen
res_value  out  RES_W-TAG_W  captured result >> TAG_W
res_tag  out  TAG_W  captured result[TAG_W-1:0]
gc_active  out  1  registered state[GC_BIT]
cycle_count  out  CNT_W  cycles spent in RUN
gc_count  out  CNT_W  number of GC starts
gc_cycles  out  CNT_W  RUN cycles with GC bit high
heap_max  out  HEAP_W  heap high-water mark
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_kind  out  4  {finish, heap_chg, gc_fall, gc_rise}
ev_time  out  CNT_W  cycle_count at event
ev_heap  out  HEAP_W  heap value at event
ev_result  out  RES_W  result value at event
overflow  out  1  sticky: event dropped on full FIFO

Behaviour:
Reset values:
- All outputs 0; FIFO empty; state RUN.
- gc_prev = 0, heap_prev = 0.

Sampling (each edge, state RUN):
- rise = state[GC_BIT] & ~gc_prev
- fall = ~state[GC_BIT] & gc_prev
- hchg = heap != heap_prev
- fin = finish
- Then gc_prev <= state[GC_BIT], heap_prev <= heap.
- gc_active equals gc_prev.
- First sample after reset with heap != 0 gives a heap_chg event.

Counters (RUN only):
- cycle_count increments every cycle.
- gc_count increments on rise.
- gc_cycles increments when state[GC_BIT] = 1.
- heap_max <= max(heap_max, heap).
- All counters saturate at all-ones; no wrap.

Events:
- Any of rise/fall/hchg/fin set gives exactly one FIFO entry for that cycle: kind mask, ev_time = cycle_count before increment, ev_heap = heap, ev_result = result.
- Simultaneous kinds share one entry.

FIFO:
- Registered write; head shown from storage (first-word fall-through).
- A push into an empty FIFO makes ev_valid high on the cycle after the sampling edge.
- Pop when ev_valid & ev_ready.
- Push while full and no pop: entry dropped, overflow <= 1.
- Push while full with pop: push accepted.
- Empty: ev_valid = 0; other ev_* outputs hold their last value.
- Pointers wrap modulo EV_DEPTH using an extra bit for full/empty.

State machine:
- RUN -> DONE on first fin: latch res_value/res_tag from result, done <= 1, emit finish event.
- DONE: sampling, counters and event generation frozen; FIFO still drains; finish ignored.
- DONE -> RUN only via clear or reset.

clear (sync, highest priority over same-cycle events):
- Zeroes counters, heap_max, done, res_*, overflow, gc_prev, heap_prev.
- Flushes FIFO; returns to RUN.

Async reset mid-operation: immediate return to reset values regardless of clock.

Optional Feature:
MONITOR_HEAP_EVENTS_EN
- Defined: hchg contributes to ev_kind[2] and alone creates entries.
- Undefined: hchg is never generated and ev_kind[2] is always 0; heap-only cycles create no entries. heap_prev/heap_max tracking is unchanged.
- Needed because heap-change traffic overflows small FIFOs during GC.

Test Plan:
1. Reset; heap=0, state=0, finish=0 for 10 cycles -> cycle_count=10, ev_valid=0, all stats 0.
2. State bit5 high at cycle 3, low at cycle 7, ev_ready=1 -> entries kind=0001 time=3 and kind=0010 time=7; gc_count=1, gc_cycles=4, gc_active follows one cycle late.
3. With MONITOR_HEAP_EVENTS_EN: heap steps 0->5->5->9 at cycles 2..4 -> kind=0100 at times 2 and 4, heap_max=9. Undefined: no entries, heap_max=9.
4. ev_ready=0 with 9 GC edges, EV_DEPTH=8 -> 8 entries held, overflow=1. Assert ready on a full FIFO during an edge -> both pop and push succeed.
5. finish=1 with result=0x0153 at cycle 20, GC rising the same cycle -> one entry kind=1001 time=20; done=1, res_value=0x2A, res_tag=3; counters frozen afterwards.
6. clear in DONE together with a GC edge -> no entry, FIFO empty, done=0, counters 0. Async reset mid-GC -> outputs 0 immediately.

Source files
------------

// File: rtl/reduceron_run_monitor_if.sv
// reduceron_run_monitor_if
// Event stream from the run monitor to a host or debug port.
// The monitor drives the head of its event FIFO; the consumer
// acknowledges it with ev_ready.
//
// Signals:
//   ev_valid   FIFO head valid (monitor -> consumer)
//   ev_ready   consumer accepts head (consumer -> monitor)
//   ev_kind    {finish, heap_chg, gc_fall, gc_rise}
//   ev_time    cycle_count at which the event was sampled
//   ev_heap    heap pointer at the event
//   ev_result  result bus at the event
//
// Modports: master = monitor side, slave = consumer side.
interface reduceron_run_monitor_if #(
    parameter int RES_W  = 16,
    parameter int HEAP_W = 13,
    parameter int CNT_W  = 32
);
    logic              ev_valid;
    logic              ev_ready;
    logic [3:0]        ev_kind;
    logic [CNT_W-1:0]  ev_time;
    logic [HEAP_W-1:0] ev_heap;
    logic [RES_W-1:0]  ev_result;

    modport master (
        output ev_valid, ev_kind, ev_time, ev_heap, ev_result,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_kind, ev_time, ev_heap, ev_result,
        output ev_ready
    );
endinterface

// File: rtl/reduceron_run_monitor.sv
// reduceron_run_monitor
// Watches a Reduceron core every clock: counts run cycles, GC starts
// and GC cycles, tracks the heap high-water mark, and queues
// timestamped events (GC rise/fall, heap change, finish) in a small
// first-word-fall-through FIFO. When finish is seen the result is
// captured and the monitor freezes until clear or reset.
//
// Optional feature macro: MONITOR_HEAP_EVENTS_EN
//   defined   -> heap pointer changes generate events (ev_kind[2])
//   undefined -> no heap-change events; heap tracking still runs
//
// Ports:
//   clock, reset          clock (rising edge), async active-high reset
//   result, state, heap,  core outputs being sampled
//   finish
//   clear                 synchronous restart (flush FIFO, zero stats)
//   done                  finish captured, monitor frozen
//   res_value, res_tag    captured result split into value and tag
//   gc_active             registered GC bit of state
//   cycle_count, gc_count, gc_cycles, heap_max   statistics
//   overflow              sticky: an event was dropped on a full FIFO
//   ev                    event stream (master modport)
module reduceron_run_monitor #(
    parameter int RES_W    = 16,
    parameter int TAG_W    = 3,
    parameter int STATE_W  = 7,
    parameter int GC_BIT   = 5,
    parameter int HEAP_W   = 13,
    parameter int CNT_W    = 32,
    parameter int EV_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RES_W-1:0]       result,
    input  logic [STATE_W-1:0]     state,
    input  logic [HEAP_W-1:0]      heap,
    input  logic                   finish,
    input  logic                   clear,
    output logic                   done,
    output logic [RES_W-TAG_W-1:0] res_value,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   gc_active,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       gc_count,
    output logic [CNT_W-1:0]       gc_cycles,
    output logic [HEAP_W-1:0]      heap_max,
    output logic                   overflow,
    reduceron_run_monitor_if.master ev
);

    localparam int AW = $clog2(EV_DEPTH);
    localparam int EW = 4 + CNT_W + HEAP_W + RES_W;
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef MONITOR_HEAP_EVENTS_EN
    localparam logic heap_ev_en = 1'b1;
`else
    localparam logic heap_ev_en = 1'b0;
`endif

    typedef enum logic {ST_RUN, ST_DONE} mon_state_t;

    mon_state_t        mstate;
    logic              gc_prev;
    logic [HEAP_W-1:0] heap_prev;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [EW-1:0]     mem [EV_DEPTH];
    logic [EW-1:0]     hold;

    logic              gc_now, rise, fall, hchg, running;
    logic [3:0]        kind;
    logic              push_req, push_ok, pop, fifo_empty, fifo_full;
    logic [EW-1:0]     head;
    logic [EW-1:0]     entry;
    logic              unused_state_bits;

    // Only the GC bit of the state bus matters here.
    assign unused_state_bits = ^state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Edge detection against the previous sample and FIFO status.
    // When the FIFO is empty the head shows the last popped entry so
    // the ev_* payload holds steady while ev_valid is low.
    always_comb begin
        gc_now     = state[GC_BIT];
        rise       = gc_now & ~gc_prev;
        fall       = ~gc_now & gc_prev;
        hchg       = heap_ev_en & (heap != heap_prev);
        running    = (mstate == ST_RUN);
        kind       = {finish, hchg, fall, rise};
        push_req   = running & (kind != 4'b0000);
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = ~fifo_empty & ev.ev_ready;
        push_ok    = push_req & (~fifo_full | pop);
        head       = fifo_empty ? hold : mem[rd_ptr[AW-1:0]];
        entry      = {kind, cycle_count, heap, result};
    end

    assign ev.ev_valid = ~fifo_empty;
    assign {ev.ev_kind, ev.ev_time, ev.ev_heap, ev.ev_result} = head;
    assign gc_active = gc_prev;

    // Event storage; pointers live in the control block below, so a
    // write during clear or reset is harmless.
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    // Control: RUN/DONE state, statistics, FIFO pointers and captured
    // result. clear outranks everything that happens in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstate      <= ST_RUN;
            done        <= 1'b0;
            res_value   <= '0;
            res_tag     <= '0;
            gc_prev     <= 1'b0;
            heap_prev   <= '0;
            cycle_count <= '0;
            gc_count    <= '0;
            gc_cycles   <= '0;
            heap_max    <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold        <= '0;
        end else if (clear) begin
            mstate      <= ST_RUN;
            done        <= 1'b0;
            res_value   <= '0;
            res_tag     <= '0;
            gc_prev     <= 1'b0;
            heap_prev   <= '0;
            cycle_count <= '0;
            gc_count    <= '0;
            gc_cycles   <= '0;
            heap_max    <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold        <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                hold   <= head;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end else if (push_req) begin
                overflow <= 1'b1;
            end
            if (running) begin
                cycle_count <= sat_inc(cycle_count);
                if (rise) begin
                    gc_count <= sat_inc(gc_count);
                end
                if (gc_now) begin
                    gc_cycles <= sat_inc(gc_cycles);
                end
                if (heap > heap_max) begin
                    heap_max <= heap;
                end
                gc_prev   <= gc_now;
                heap_prev <= heap;
                if (finish) begin
                    mstate    <= ST_DONE;
                    done      <= 1'b1;
                    res_value <= result[RES_W-1:TAG_W];
                    res_tag   <= result[TAG_W-1:0];
                end
            end
        end
    end

endmodule
